// File: rtl/display_pkg.sv
// Shared constants and types for the seven-segment display mux.
package display_pkg;

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  typedef logic [1:0] digit_idx_t;
  typedef logic [3:0] nibble_t;

endpackage

// File: rtl/module_display_mux_if.sv
// Datapath-facing bus of the display mux: value/load/blanking in, pin drives out.
interface module_display_mux_if;
  logic [15:0] value_i;
  logic        load_i;
  logic        blank_lz_i;
  logic [6:0]  seg_o;
  logic [3:0]  an_o;
  logic        slot_tick_o;

  modport master (
    output value_i, load_i, blank_lz_i,
    input  seg_o, an_o, slot_tick_o
  );

  modport slave (
    input  value_i, load_i, blank_lz_i,
    output seg_o, an_o, slot_tick_o
  );
endinterface

// File: rtl/module_sevenseg.sv
// Hex nibble to active-low seven-segment pattern, seg = {g,f,e,d,c,b,a}.
module module_sevenseg
  import display_pkg::*;
(
  input  nibble_t    num,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (num)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/module_display_mux.sv
// Scans a captured 16-bit value across a 4-digit common-anode display, one digit per slot,
// with a blanking window at the start of each slot and optional leading-zero suppression.
module module_display_mux
  import display_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 27000,
  parameter int unsigned BLANK_CYC = 270,
  parameter int unsigned N_DIGITS  = 4
) (
  input logic                 clk,
  input logic                 rst,
  module_display_mux_if.slave bus_if
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CntW-1:0] CntMax   = CntW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] BlankEnd = CntW'(BLANK_CYC);
  localparam digit_idx_t      IdxMax   = digit_idx_t'(N_DIGITS - 1);

  logic [CntW-1:0] div_cnt_q, div_cnt_d;
  digit_idx_t      idx_q, idx_d;
  logic [15:0]     value_q, value_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            tick_q, tick_d;

  nibble_t    nibble;
  logic [6:0] seg_dec;
  logic       lead_zero;

  module_sevenseg u_sevenseg (
    .num (nibble),
    .seg (seg_dec)
  );

  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    idx_d     = idx_q;
    tick_d    = 1'b0;
    if (div_cnt_q == CntMax) begin
      div_cnt_d = '0;
      idx_d     = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
      tick_d    = 1'b1;
    end

    value_d = bus_if.load_i ? bus_if.value_i : value_q;

    nibble = value_q[{idx_q, 2'b00} +: 4];
    // Digit k is a leading zero when every digit at or above k is zero.
    lead_zero = bus_if.blank_lz_i && (idx_q != '0) && ((value_q >> {idx_q, 2'b00}) == 16'h0);

    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    if (div_cnt_q >= BlankEnd && !lead_zero) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = seg_dec;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
      idx_q     <= '0;
      value_q   <= '0;
      an_q      <= AN_OFF;
      seg_q     <= SEG_OFF;
      tick_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      idx_q     <= idx_d;
      value_q   <= value_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      tick_q    <= tick_d;
    end
  end

  assign bus_if.an_o        = an_q;
  assign bus_if.seg_o       = seg_q;
  assign bus_if.slot_tick_o = tick_q;

endmodule

// File: tb/tb_module_display_mux.sv
// Directed and random checks of the display mux with SCAN_DIV=8, BLANK_CYC=2.
module tb_module_display_mux;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  module_display_mux_if dif ();

  module_display_mux #(
    .SCAN_DIV  (8),
    .BLANK_CYC (2),
    .N_DIGITS  (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (dif)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       tick;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [15:0] val_m = 16'h0;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, want);
    end
  endtask

  // Push the expected output for the coming edge, clock once, then pop and compare.
  task automatic step();
    exp_t        e;
    int          cnt = cyc % 8;
    int          idx = (cyc / 8) % 4;
    logic [15:0] nxt;
    e.an   = 4'hF;
    e.seg  = 7'h7F;
    e.tick = (cnt == 7);
    if (cnt >= 2 && !(dif.blank_lz_i && idx > 0 && (val_m >> (4 * idx)) == 16'h0)) begin
      e.an  = ~(4'b0001 << idx);
      e.seg = hex7(val_m[4*idx +: 4]);
    end
    sb.push_back(e);
    nxt = dif.load_i ? dif.value_i : val_m;
    @(posedge clk);
    #1;
    cyc++;
    val_m = nxt;
    e = sb.pop_front();
    chk("an", 32'(dif.an_o), 32'(e.an));
    chk("seg", 32'(dif.seg_o), 32'(e.seg));
    chk("tick", 32'(dif.slot_tick_o), 32'(e.tick));
    chk("an_onehot", 32'($countones(~dif.an_o) <= 1), 32'd1);
  endtask

  task automatic run_until(input int target);
    while (cyc % 32 != target) step();
  endtask

  task automatic load_and_run(input logic [15:0] v, input logic blz, input int n);
    dif.value_i    = v;
    dif.blank_lz_i = blz;
    dif.load_i     = 1'b1;
    step();
    dif.load_i = 1'b0;
    repeat (n - 1) step();
  endtask

  initial begin
    dif.value_i    = 16'h0;
    dif.load_i     = 1'b0;
    dif.blank_lz_i = 1'b0;

    @(posedge clk);
    #1;
    chk("rst_an", 32'(dif.an_o), 32'hF);
    chk("rst_seg", 32'(dif.seg_o), 32'h7F);
    chk("rst_tick", 32'(dif.slot_tick_o), 32'h0);
    #2 rst = 1'b0;
    cyc = 0;

    // Full-frame scan of 1234 without suppression.
    load_and_run(16'h1234, 1'b0, 40);

    // Leading-zero suppression hides digits 2 and 3.
    run_until(0);
    load_and_run(16'h00A5, 1'b1, 36);

    // Zero value: one digit with suppression, four without.
    run_until(0);
    load_and_run(16'h0000, 1'b1, 36);
    run_until(0);
    load_and_run(16'h0000, 1'b0, 36);

    // Mid-slot load lands on the very next digit-1 output.
    run_until(0);
    load_and_run(16'hFFFF, 1'b0, 8);
    run_until(11);
    dif.value_i = 16'h0C00;
    dif.load_i  = 1'b1;
    step();
    dif.load_i = 1'b0;
    step();
    chk("midload_an", 32'(dif.an_o), 32'hD);
    chk("midload_seg", 32'(dif.seg_o), 32'h40);
    repeat (24) step();

    // Asynchronous reset in the middle of slot 2.
    run_until(20);
    rst = 1'b1;
    #1;
    chk("async_an", 32'(dif.an_o), 32'hF);
    chk("async_seg", 32'(dif.seg_o), 32'h7F);
    chk("async_tick", 32'(dif.slot_tick_o), 32'h0);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("hold_an", 32'(dif.an_o), 32'hF);
      chk("hold_seg", 32'(dif.seg_o), 32'h7F);
    end
    #2 rst = 1'b0;
    cyc   = 0;
    val_m = 16'h0;
    load_and_run(16'h1234, 1'b0, 40);

    // Random loads and blanking mode.
    for (int i = 0; i < 1000; i++) begin
      dif.load_i     = ($urandom_range(0, 3) == 0);
      dif.value_i    = 16'($urandom);
      dif.blank_lz_i = 1'($urandom_range(0, 1));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
